// File: rtl/exu_seq_swc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exu_seq_swc: execution sequencer stepping one decoded instruction through  |
// | its execution units with stall support and a retired-instruction counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exu_seq_swc #(
   parameter int ALU_CYCLES = 4,
   parameter int LSU_CYCLES = 6
) (
   input  logic        hclk,
   input  logic        hrstn,
   input  logic        dec_valid,
   input  logic [2:0]  dec_class,
   output logic        dec_ready,
   input  logic        exu_stall,
   output logic [3:0]  cycle_cnt,
   output logic        en_reg,
   output logic        en_imm,
   output logic        en_lsu,
   output logic        en_bru,
   output logic        exu_done,
   output logic        exu_illegal,
   output logic [31:0] retire_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] c_cls_reg   = 3'd0;
   localparam logic [2:0] c_cls_imm   = 3'd1;
   localparam logic [2:0] c_cls_load  = 3'd2;
   localparam logic [2:0] c_cls_store = 3'd3;
   localparam logic [2:0] c_cls_bru   = 3'd4;
   localparam logic [3:0] c_alu_last  = 4'(ALU_CYCLES);
   localparam logic [3:0] c_lsu_last  = 4'(LSU_CYCLES);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_class, w_class_nxt;
   logic [3:0]  r_cnt,   w_cnt_nxt;
   logic [3:0]  r_en,    w_en_nxt;      // {bru, lsu, imm, reg}
   logic        r_illegal, w_illegal_nxt;
   logic [31:0] r_retire_cnt;
   logic [3:0]  w_last;
   logic [3:0]  w_en_dec;
   logic        w_legal;

   assign w_legal = (dec_class <= c_cls_bru);
   assign w_last  = ((r_class == c_cls_load) || (r_class == c_cls_store)) ? c_lsu_last : c_alu_last;

   always_comb begin
      w_en_dec = 4'b1000;
      case (dec_class)
         c_cls_reg:               w_en_dec = 4'b0001;
         c_cls_imm:               w_en_dec = 4'b0010;
         c_cls_load, c_cls_store: w_en_dec = 4'b0100;
         default:                 w_en_dec = 4'b1000;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_class_nxt   = r_class;
      w_cnt_nxt     = r_cnt;
      w_en_nxt      = r_en;
      w_illegal_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dec_valid) begin
               // Illegal classes are flagged but never enter RUN.
               if (w_legal) begin
                  w_state_nxt = ST_RUN;
                  w_class_nxt = dec_class;
                  w_cnt_nxt   = 4'd1;
                  w_en_nxt    = w_en_dec;
               end else begin
                  w_illegal_nxt = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!exu_stall) begin
               if (r_cnt == w_last) begin
                  w_state_nxt = ST_DONE;
                  w_cnt_nxt   = 4'd0;
                  w_en_nxt    = 4'b0000;
               end else begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_state      <= ST_IDLE;
         r_class      <= c_cls_reg;
         r_cnt        <= 4'd0;
         r_en         <= 4'b0000;
         r_illegal    <= 1'b0;
         r_retire_cnt <= 32'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_class   <= w_class_nxt;
         r_cnt     <= w_cnt_nxt;
         r_en      <= w_en_nxt;
         r_illegal <= w_illegal_nxt;
         if (r_state == ST_DONE) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
      end
   end

   assign dec_ready   = (r_state == ST_IDLE);
   assign exu_done    = (r_state == ST_DONE);
   assign exu_illegal = r_illegal;
   assign cycle_cnt   = r_cnt;
   assign en_reg      = r_en[0];
   assign en_imm      = r_en[1];
   assign en_lsu      = r_en[2];
   assign en_bru      = r_en[3];
   assign retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exu_seq_swc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exu_seq_swc: scoreboard bench for exu_seq_swc with a cycle-level model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_exu_seq_swc;

   localparam int ALU = 4;
   localparam int LSU = 6;

   logic        hclk = 1'b0;
   logic        hrstn = 1'b0;
   logic        dec_valid = 1'b0;
   logic [2:0]  dec_class = 3'd0;
   logic        exu_stall = 1'b0;
   logic        dec_ready;
   logic [3:0]  cycle_cnt;
   logic        en_reg, en_imm, en_lsu, en_bru;
   logic        exu_done, exu_illegal;
   logic [31:0] retire_cnt;
   logic [3:0]  en;

   assign en = {en_bru, en_lsu, en_imm, en_reg};

   exu_seq_swc #(.ALU_CYCLES(ALU), .LSU_CYCLES(LSU)) dut (
      .hclk(hclk), .hrstn(hrstn), .dec_valid(dec_valid), .dec_class(dec_class),
      .dec_ready(dec_ready), .exu_stall(exu_stall), .cycle_cnt(cycle_cnt),
      .en_reg(en_reg), .en_imm(en_imm), .en_lsu(en_lsu), .en_bru(en_bru),
      .exu_done(exu_done), .exu_illegal(exu_illegal), .retire_cnt(retire_cnt)
   );

   always #5 hclk = ~hclk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  cnt;
      logic [3:0]  en;
   } step_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic        kind;     // 1 = retire, 0 = illegal
      logic [31:0] retire;
   } ev_t;

   step_t       stq[$];
   ev_t         evq[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] cyc     = 32'd0;
   logic [31:0] m_retire = 32'd0;
   logic        pend_v = 1'b0;
   logic [31:0] pend_cyc = 32'd0;
   logic [31:0] pend_val = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] en_of(input logic [2:0] c);
      if (c == 3'd0) return 4'b0001;
      if (c == 3'd1) return 4'b0010;
      if (c == 3'd2 || c == 3'd3) return 4'b0100;
      return 4'b1000;
   endfunction

   function automatic int last_of(input logic [2:0] c);
      return (c == 3'd2 || c == 3'd3) ? LSU : ALU;
   endfunction

   // One legal instruction: accepted at the next edge, then one RUN cycle per
   // stall-or-step decision until LAST unstalled steps, then one DONE cycle.
   task automatic issue(input logic [2:0] cls, input logic [31:0] mask,
                        input bit use_mask, input bit hold_valid);
      bit          st[$];
      int          count;
      int          k;
      logic [31:0] e;
      bit          s;
      @(negedge hclk);
      dec_valid = 1'b1;
      dec_class = cls;
      exu_stall = 1'($urandom_range(0, 1));
      e = cyc + 32'd1;
      count = 0;
      k = 0;
      while (count < last_of(cls)) begin
         s = use_mask ? mask[k] : ($urandom_range(0, 3) == 0);
         stq.push_back('{cyc: e + 32'(k), cnt: 4'(count + 1), en: en_of(cls)});
         st.push_back(s);
         if (!s) count++;
         k++;
      end
      evq.push_back('{cyc: e + 32'(k), kind: 1'b1, retire: m_retire});
      m_retire = m_retire + 32'd1;
      for (int i = 0; i < st.size(); i++) begin
         @(negedge hclk);
         exu_stall = st[i];
         dec_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
         dec_class = 3'($urandom_range(0, 7));
      end
      @(negedge hclk);
      exu_stall = 1'($urandom_range(0, 1));
      dec_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      dec_class = 3'($urandom_range(0, 7));
   endtask

   task automatic illegal_insn(input logic [2:0] cls);
      @(negedge hclk);
      dec_valid = 1'b1;
      dec_class = cls;
      exu_stall = 1'($urandom_range(0, 1));
      evq.push_back('{cyc: cyc + 32'd1, kind: 1'b0, retire: m_retire});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge hclk);
         dec_valid = 1'b0;
         exu_stall = 1'($urandom_range(0, 1));
         dec_class = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_done", 32'(exu_done), 32'd0);
      chk("rst_illegal", 32'(exu_illegal), 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_ready", 32'(dec_ready), 32'd1);
   endtask

   // Monitor: pops expected steps and events as the DUT presents them.
   initial begin
      step_t st;
      ev_t   ev;
      forever begin
         @(posedge hclk);
         cyc = cyc + 32'd1;
         #1;
         while (stq.size() > 0 && stq[0].cyc < cyc) begin
            st = stq.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missed_step: cycle %0d expected cnt %0d", st.cyc, st.cnt);
         end
         if (stq.size() > 0 && stq[0].cyc == cyc) begin
            st = stq.pop_front();
            chk("run_cycle_cnt", 32'(cycle_cnt), 32'(st.cnt));
            chk("run_en", 32'(en), 32'(st.en));
         end else begin
            chk("idle_cycle_cnt", 32'(cycle_cnt), 32'd0);
            chk("idle_en", 32'(en), 32'd0);
         end
         chk("en_onehot", 32'($countones(en) <= 1), 32'd1);
         chk("dec_ready", 32'(dec_ready), 32'(cycle_cnt == 4'd0 && !exu_done));
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            ev = evq.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missed_event: kind %0d at cycle %0d was not observed", ev.kind, ev.cyc);
         end
         if (exu_done || exu_illegal) begin
            if (evq.size() == 0 || evq[0].cyc != cyc) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_event: got done=%0d illegal=%0d, expected none", exu_done, exu_illegal);
            end else begin
               ev = evq.pop_front();
               chk("event_kind", 32'({exu_done, exu_illegal}), ev.kind ? 32'd2 : 32'd1);
               chk("event_retire", retire_cnt, ev.retire);
               if (ev.kind) begin
                  pend_v   = 1'b1;
                  pend_cyc = cyc + 32'd1;
                  pend_val = ev.retire + 32'd1;
               end
            end
         end
         if (pend_v && pend_cyc == cyc) begin
            chk("retire_after_done", retire_cnt, pend_val);
            pend_v = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] e;
      logic [2:0]  cls;
      int          r;
      // Asynchronous reset is visible before any clock edge.
      #1;
      chk_reset_values();
      repeat (2) @(posedge hclk);
      #3 hrstn = 1'b1;

      issue(3'd0, 32'd0, 1'b1, 1'b0);                  // REG, no stall
      issue(3'd2, 32'b11100, 1'b1, 1'b0);              // LOAD, stall at cnt 3
      issue(3'd4, 32'b11000, 1'b1, 1'b0);              // BRU, stall at last step
      illegal_insn(3'd6);
      idle(1);

      // Reset while cycle_cnt == 2 aborts the instruction.
      @(negedge hclk);
      dec_valid = 1'b1; dec_class = 3'd2; exu_stall = 1'b0;
      e = cyc + 32'd1;
      stq.push_back('{cyc: e, cnt: 4'd1, en: 4'b0100});
      stq.push_back('{cyc: e + 32'd1, cnt: 4'd2, en: 4'b0100});
      @(negedge hclk);
      dec_valid = 1'b0;
      @(negedge hclk);
      #2;
      hrstn = 1'b0;
      stq.delete(); evq.delete(); pend_v = 1'b0; m_retire = 32'd0;
      #1;
      chk_reset_values();
      repeat (2) @(posedge hclk);
      #3 hrstn = 1'b1;
      issue(3'd1, 32'd0, 1'b1, 1'b0);                  // IMM right after reset

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) illegal_insn(3'($urandom_range(5, 7)));
         else if (r == 2) idle($urandom_range(1, 3));
         else issue(3'($urandom_range(0, 4)), 32'd0, 1'b0, 1'b0);
      end

      // Counter wrap with dec_valid held high: one acceptance every ALU+2 cycles.
      @(negedge hclk);
      dec_valid = 1'b0;
      force dut.r_retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_cnt;
      m_retire = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(0, 2);
         cls = (r == 2) ? 3'd4 : 3'(r);
         issue(cls, 32'd0, 1'b1, 1'b1);
      end
      idle(12);
      chk("step_queue_drained", 32'(stq.size()), 32'd0);
      chk("event_queue_drained", 32'(evq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exu_seq_swc.md
EXU_SEQ_SWC -- requirements
Module: exu_seq_swc

Interface
REQ-001 The block SHALL have parameter ALU_CYCLES, default 4: last cycle_cnt value for REG, IMM and BRU classes.
REQ-002 The block SHALL have parameter LSU_CYCLES, default 6: last cycle_cnt value for LOAD and STORE classes.
REQ-003 The block SHALL have port hclk, input, 1: single clock; all state on rising edge.
REQ-004 The block SHALL have port hrstn, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port dec_valid, input, 1: decoder presents a decoded instruction.
REQ-006 The block SHALL have port dec_class, input, 3: 0=REG, 1=IMM, 2=LOAD, 3=STORE, 4=BRU, 5..7 illegal.
REQ-007 The block SHALL have port dec_ready, output, 1: sequencer can accept an instruction this cycle.
REQ-008 The block SHALL have port exu_stall, input, 1: freeze the current execution step.
REQ-009 The block SHALL have port cycle_cnt, output, 4: execution step to the execution units; 0 = idle.
REQ-010 The block SHALL have ports en_reg, en_imm, en_lsu and en_bru, each output, 1: one-hot execution-unit enables.
REQ-011 The block SHALL have port exu_done, output, 1: one-cycle pulse when an instruction retires.
REQ-012 The block SHALL have port exu_illegal, output, 1: one-cycle pulse when an illegal class is accepted.
REQ-013 The block SHALL have port retire_cnt, output, 32: count of retired instructions.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 dec_ready SHALL be 1 only in IDLE.
REQ-016 IDLE with dec_valid=1 SHALL latch dec_class and move to RUN on the next edge, regardless of exu_stall.
REQ-017 On RUN entry, cycle_cnt SHALL be 1 and the enable matching the latched class SHALL be 1.
  - LOAD and STORE both assert en_lsu.
  - The enable is held for the entire RUN state.
REQ-018 In RUN with exu_stall=0 and cycle_cnt < LAST, cycle_cnt SHALL increment by 1 each cycle.
  - LAST = LSU_CYCLES for LOAD/STORE; ALU_CYCLES otherwise.
REQ-019 In RUN with exu_stall=1, cycle_cnt and all enables SHALL hold their values, with no increment.
REQ-020 In RUN with exu_stall=0 and cycle_cnt == LAST, the FSM SHALL move to DONE.
  - On that edge: cycle_cnt goes to 0 and all enables go to 0.
REQ-021 In DONE, exu_done SHALL be 1 for exactly one cycle, retire_cnt SHALL increment, and the FSM SHALL return to IDLE.
  - exu_stall has no effect in DONE.
REQ-022 A stall asserted on the cycle cycle_cnt == LAST SHALL delay the transition to DONE until the stall releases.
REQ-023 An illegal class accepted in IDLE SHALL not enter RUN.
  - Next cycle: exu_illegal=1 for one cycle, FSM stays in IDLE, no enable asserted, retire_cnt unchanged.
  - dec_ready stays 1 during that cycle.
REQ-024 Minimum per-instruction occupancy SHALL be LAST+2 cycles: accept, RUN×LAST, DONE.
REQ-025 dec_valid SHALL be ignored outside IDLE, with no queuing.
REQ-026 retire_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without any flag.
REQ-027 At most one of en_reg, en_imm, en_lsu and en_bru SHALL be 1 in any cycle.
REQ-028 cycle_cnt SHALL be nonzero if and only if the FSM is in RUN.
REQ-029 ALU_CYCLES and LSU_CYCLES SHALL each be in the range 1..15; values outside that range are unsupported.

Reset
REQ-030 hrstn=0 SHALL immediately force the following, independent of hclk:
  - state IDLE; cycle_cnt=0; all en_*=0;
  - exu_done=0, exu_illegal=0, retire_cnt=0;
  - latched class = REG.
REQ-031 With hrstn=0, dec_ready SHALL be 1, since the FSM is in IDLE.
REQ-032 Reset asserted mid-RUN SHALL abort the instruction.
  - No exu_done pulse.
  - No retire_cnt increment.
REQ-033 The first rising hclk edge after hrstn deasserts SHALL be able to accept an instruction.

Verification
REQ-034 REG instruction, no stall:
  - stimulus: dec_valid=1, dec_class=0 for one cycle at T0;
  - response: T1..T4 cycle_cnt=1,2,3,4 with en_reg=1; T5 exu_done=1 with cycle_cnt=0; T6 dec_ready=1; retire_cnt=1.
REQ-035 LOAD instruction with stall:
  - stimulus: dec_class=2; exu_stall=1 for 3 cycles starting at cycle_cnt=3;
  - response: cycle_cnt reads 1,2,3,3,3,3,4,5,6 with en_lsu=1 throughout; exu_done at the 10th cycle after accept.
REQ-036 Stall at the last step:
  - stimulus: BRU instruction; exu_stall=1 for 2 cycles while cycle_cnt=4;
  - response: cycle_cnt stays 4 for 3 cycles; exu_done is delayed by 2 cycles; en_bru=1 until the DONE transition.
REQ-037 Illegal class:
  - stimulus: dec_class=6;
  - response: next cycle exu_illegal=1 for one cycle; cycle_cnt=0; all en_*=0; retire_cnt unchanged; dec_ready=1.
REQ-038 Reset mid-RUN:
  - stimulus: hrstn=0 while cycle_cnt=2;
  - response: asynchronously cycle_cnt=0, en_*=0, retire_cnt=0; no exu_done; a following IMM instruction runs normally, cycle_cnt 1..4 with en_imm=1.
REQ-039 Back-to-back instructions and counter wrap:
  - stimulus: force retire_cnt=0xFFFFFFFF; hold dec_valid=1 continuously;
  - response: one acceptance every 6 cycles for ALU_CYCLES=4; dec_valid ignored in RUN/DONE; retire_cnt wraps to 0 at the first retire.
